ipf_seq: RTL and testbench
==========================

# ipf_seq

Sequencer in front of the IPF convolution engine. On a start pulse it fetches input tiles and weight sets from two 1-cycle-latency buffer memories and streams them into IPF's `i_data`/`w_data` ports. It drives IPF's `ctrl` command level through the load → compute → next → flush schedule, then waits for IPF `finish`. It also counts `res_valid` beats, replacing the hand-written stimulus loop used to run IPF today.

## Interface
- `D_Width`, 64 — data beat width (IPF `i_data`/`w_data`)
- `A_Width`, 16 — buffer address width
- `I_BEATS`, 8 — input beats per tile
- `W_BEATS`, 4 — beats per weight set
- `W_SETS_PER_I`, 2 — weight sets applied to each input tile
- `W_SET_NUM`, 2 — weight sets stored in the weight buffer; the weight address wraps after `W_SET_NUM*W_BEATS` beats
- `TILES`, 2 — input tiles per run
- `COMPUTE_CYC`, 32 — cycles `ctrl`=1 is held per weight set
- `clk` in 1 — clock
- `rst` in 1 — asynchronous, active-low reset
- `start` in 1 — run request; sampled in IDLE only
- `busy` out 1 — high from start acceptance through DONE
- `done` out 1 — one-cycle pulse at run end
- `res_cnt` out 16 — `res_valid` beats seen this run
- `i_rd` out 1, `i_addr` out A_Width — input buffer read
- `i_rdata` in D_Width — input buffer data, valid 1 cycle after `i_rd`
- `w_rd` out 1, `w_addr` out A_Width — weight buffer read
- `w_rdata` in D_Width — weight buffer data, valid 1 cycle after `w_rd`
- `ctrl` out 3 — IPF command level: 0 idle/flush, 1 compute, 2 next; 3-7 never driven
- `i_valid` out 1, `i_data` out D_Width — to IPF
- `w_valid` out 1, `w_data` out D_Width — to IPF
- `res_valid` in 1, `finish` in 1 — from IPF

## Operation
- States: IDLE, LD_I, LD_W, DRAIN, COMPUTE, FLUSH, DONE.
- IDLE → LD_I when `start`=1. On acceptance:
  - clear `res_cnt`, the `finish_seen` flag and all counters;
  - `i_addr`=0, `w_addr`=0.
- LD_I:
  - `i_rd`=1 for `I_BEATS` cycles; `i_addr` increments each cycle.
  - Then → LD_W. `i_addr` is never reset within a run, so tile t reads addresses t*`I_BEATS` … t*`I_BEATS`+`I_BEATS`-1.
- LD_W:
  - `w_rd`=1 for `W_BEATS` cycles; `w_addr` increments, wrapping to 0 after `W_SET_NUM*W_BEATS`-1.
  - Then → DRAIN (one cycle, no reads; last `w_valid` beat on the bus) → COMPUTE.
- COMPUTE:
  - lasts `COMPUTE_CYC` cycles with `ctrl`=1;
  - if more weight sets remain for this tile → LD_W;
  - else if more tiles remain → LD_I;
  - else → FLUSH.
- `ctrl` levels:
  - 0 from reset until the first COMPUTE;
  - 1 in COMPUTE;
  - 2 in every LD_I/LD_W/DRAIN after the first COMPUTE;
  - 0 in FLUSH, DONE and IDLE.
- `i_valid`/`w_valid` are `i_rd`/`w_rd` registered by one cycle. `i_data`/`w_data` pass `i_rdata`/`w_rdata` through. Valid beats on the two channels never overlap.
- FLUSH: waits for `finish`=1, or exits on the first FLUSH cycle if `finish_seen` is already set. Then → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `finish_seen` sets on any `finish`=1 while busy.
- `res_cnt` increments on every `res_valid`=1 cycle while busy. It saturates at 16'hFFFF and holds its value in IDLE until the next start.
- `start` while busy is ignored. `start` held high in the DONE cycle does not start a new run; a new run starts only on a `start` sampled in IDLE.

## Timing
- Reset values: all outputs 0; state IDLE.
- Asynchronous reset mid-run:
  - returns to IDLE immediately with all outputs 0;
  - no `done` pulse;
  - the in-flight `i_valid`/`w_valid` beat is dropped.
- Cycle numbering: cycle k is the k-th cycle after the edge that samples `start`. With default parameters:
  - `i_rd` cycles 1-8; `i_valid` cycles 2-9;
  - `w_rd` cycles 9-12; `w_valid` cycles 10-13;
  - DRAIN cycle 13; `ctrl`=1 cycles 14-45;
  - set 2: `ctrl`=2 from cycle 46, `w_rd` 46-49, `w_valid` 47-50, `ctrl`=1 cycles 51-82;
  - tile 2 `i_rd` from cycle 83; FLUSH (`ctrl`=0) from cycle 165.
- Per-tile length: `I_BEATS` + `W_SETS_PER_I`*(`W_BEATS`+1+`COMPUTE_CYC`) cycles.
- `done` asserts 1 cycle after the first FLUSH cycle in which `finish` or `finish_seen` is high. `busy` drops in the same cycle as `done`.

## Test plan
- Default parameters, buffers holding distinct patterns, IPF model raising `finish` 5 cycles into FLUSH. Required:
  - `i_valid` beats = input words 0-15;
  - `w_valid` beats = weight words 0-3, 4-7, 0-3, 4-7;
  - `ctrl` edges exactly at cycles 14/46/51/83/…/165;
  - `done` pulse at cycle 171.
- Weight wrap with `W_SET_NUM`=1, `W_SETS_PER_I`=2: `w_addr` sequence 0-3, 0-3, 0-3, 0-3.
- `finish` pulsed at cycle 100 (before FLUSH) → DONE on the first FLUSH cycle (165), `done` at 166.
- `res_valid` toggled 200 times during the run → `res_cnt`=200, held after `done`. A new `start` clears it to 0.
- `start` re-pulsed at cycles 20 and 60 → ignored: same beat counts and `done` timing as a single run.
- `rst` low at cycle 30 for 2 cycles → outputs 0, state IDLE, no `done`. A fresh `start` then reproduces the first scenario's timeline exactly.

Source files
------------

// File: rtl/ipf_seq.sv
`timescale 1ns/1ps
// ipf_seq: run sequencer for the IPF convolution engine.
// Fetches input tiles and weight sets from two buffers that return data one
// cycle after the read strobe. It streams the beats into IPF, steps the ctrl
// level through load/compute/next/flush, and counts result beats.
module ipf_seq #(
   parameter int D_Width      = 64,
   parameter int A_Width      = 16,
   parameter int I_BEATS      = 8,
   parameter int W_BEATS      = 4,
   parameter int W_SETS_PER_I = 2,
   parameter int W_SET_NUM    = 2,
   parameter int TILES        = 2,
   parameter int COMPUTE_CYC  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [15:0]        res_cnt,
   output logic               i_rd,
   output logic [A_Width-1:0] i_addr,
   input  logic [D_Width-1:0] i_rdata,
   output logic               w_rd,
   output logic [A_Width-1:0] w_addr,
   input  logic [D_Width-1:0] w_rdata,
   output logic [2:0]         ctrl,
   output logic               i_valid,
   output logic [D_Width-1:0] i_data,
   output logic               w_valid,
   output logic [D_Width-1:0] w_data,
   input  logic               res_valid,
   input  logic               finish
);

   // Terminal counts, sized to the counters they are compared against
   localparam logic [15:0]        I_LAST      = 16'(I_BEATS - 1);
   localparam logic [15:0]        W_LAST      = 16'(W_BEATS - 1);
   localparam logic [15:0]        C_LAST      = 16'(COMPUTE_CYC - 1);
   localparam logic [15:0]        S_LAST      = 16'(W_SETS_PER_I - 1);
   localparam logic [15:0]        T_LAST      = 16'(TILES - 1);
   localparam logic [A_Width-1:0] W_ADDR_LAST = A_Width'(W_SET_NUM * W_BEATS - 1);
   localparam logic [A_Width-1:0] ADDR_ONE    = A_Width'(1);

   // IPF command levels
   localparam logic [2:0] CTRL_IDLE    = 3'd0;
   localparam logic [2:0] CTRL_COMPUTE = 3'd1;
   localparam logic [2:0] CTRL_NEXT    = 3'd2;

   typedef enum logic [2:0] {
      IDLE, LD_I, LD_W, DRAIN, COMPUTE, FLUSH, DONE
   } state_t;

   state_t      state_reg;
   logic [15:0] cnt_reg;          // beat / compute-cycle counter within a phase
   logic [15:0] set_reg;          // weight set index within the current tile
   logic [15:0] tile_reg;         // tile index within the run
   logic        finish_seen_reg;  // IPF finished before we reached FLUSH

   // Buffer data is only forwarded while its valid is up, so idle buses read 0
   assign i_data = i_valid ? i_rdata : '0;
   assign w_data = w_valid ? w_rdata : '0;

   // Run FSM; ctrl and the read strobes are set on the edge entering each phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         set_reg         <= '0;
         tile_reg        <= '0;
         finish_seen_reg <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         res_cnt         <= '0;
         i_rd            <= 1'b0;
         i_addr          <= '0;
         w_rd            <= 1'b0;
         w_addr          <= '0;
         ctrl            <= CTRL_IDLE;
         i_valid         <= 1'b0;
         w_valid         <= 1'b0;
      end else begin
         i_valid <= i_rd;
         w_valid <= w_rd;
         done    <= 1'b0;
         if (busy && finish)
            finish_seen_reg <= 1'b1;
         if (busy && res_valid && (res_cnt != 16'hFFFF))
            res_cnt <= res_cnt + 16'd1;

         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg       <= LD_I;
                  busy            <= 1'b1;
                  i_rd            <= 1'b1;
                  i_addr          <= '0;
                  w_addr          <= '0;
                  res_cnt         <= '0;
                  finish_seen_reg <= 1'b0;
                  cnt_reg         <= '0;
                  set_reg         <= '0;
                  tile_reg        <= '0;
               end
            end
            LD_I: begin
               // i_addr keeps counting across tiles, so tile t follows tile t-1
               i_addr  <= i_addr + ADDR_ONE;
               cnt_reg <= cnt_reg + 16'd1;
               if (cnt_reg == I_LAST) begin
                  cnt_reg   <= '0;
                  i_rd      <= 1'b0;
                  w_rd      <= 1'b1;
                  state_reg <= LD_W;
               end
            end
            LD_W: begin
               w_addr  <= (w_addr == W_ADDR_LAST) ? '0 : w_addr + ADDR_ONE;
               cnt_reg <= cnt_reg + 16'd1;
               if (cnt_reg == W_LAST) begin
                  cnt_reg   <= '0;
                  w_rd      <= 1'b0;
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               // last weight beat is on the bus this cycle
               ctrl      <= CTRL_COMPUTE;
               state_reg <= COMPUTE;
            end
            COMPUTE: begin
               cnt_reg <= cnt_reg + 16'd1;
               if (cnt_reg == C_LAST) begin
                  cnt_reg <= '0;
                  if (set_reg != S_LAST) begin
                     set_reg   <= set_reg + 16'd1;
                     w_rd      <= 1'b1;
                     ctrl      <= CTRL_NEXT;
                     state_reg <= LD_W;
                  end else if (tile_reg != T_LAST) begin
                     set_reg   <= '0;
                     tile_reg  <= tile_reg + 16'd1;
                     i_rd      <= 1'b1;
                     ctrl      <= CTRL_NEXT;
                     state_reg <= LD_I;
                  end else begin
                     ctrl      <= CTRL_IDLE;
                     state_reg <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (finish || finish_seen_reg) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               // start is deliberately not sampled here
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ipf_seq.sv
`timescale 1ns/1ps
// tb_ipf_seq: directed test of the IPF run sequencer.
module tb_ipf_seq;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (default parameters)
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        res_valid = 1'b0;
   logic        finish = 1'b0;
   logic        busy, done, i_rd, w_rd, i_valid, w_valid;
   logic [15:0] res_cnt, i_addr, w_addr;
   logic [2:0]  ctrl;
   logic [63:0] i_rdata = '0;
   logic [63:0] w_rdata = '0;
   logic [63:0] i_data, w_data;

   // weight-wrap instance
   logic        start2 = 1'b0;
   logic        res_valid2 = 1'b0;
   logic        finish2 = 1'b1;
   logic        busy2, done2, i_rd2, w_rd2, i_valid2, w_valid2;
   logic [15:0] res_cnt2, i_addr2, w_addr2;
   logic [2:0]  ctrl2;
   logic [63:0] i_rdata2 = '0;
   logic [63:0] w_rdata2 = '0;
   logic [63:0] i_data2, w_data2;

   logic [63:0] i_mem [0:63];
   logic [63:0] w_mem [0:63];

   ipf_seq u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .res_cnt(res_cnt), .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata),
      .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata), .ctrl(ctrl),
      .i_valid(i_valid), .i_data(i_data), .w_valid(w_valid), .w_data(w_data),
      .res_valid(res_valid), .finish(finish)
   );

   ipf_seq #(.W_SET_NUM(1), .W_SETS_PER_I(2), .COMPUTE_CYC(4)) u_wrap (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
      .res_cnt(res_cnt2), .i_rd(i_rd2), .i_addr(i_addr2), .i_rdata(i_rdata2),
      .w_rd(w_rd2), .w_addr(w_addr2), .w_rdata(w_rdata2), .ctrl(ctrl2),
      .i_valid(i_valid2), .i_data(i_data2), .w_valid(w_valid2), .w_data(w_data2),
      .res_valid(res_valid2), .finish(finish2)
   );

   // buffer models: one-cycle read latency
   always @(posedge clk) begin
      if (i_rd)  i_rdata  <= i_mem[i_addr[5:0]];
      if (w_rd)  w_rdata  <= w_mem[w_addr[5:0]];
      if (i_rd2) i_rdata2 <= i_mem[i_addr2[5:0]];
      if (w_rd2) w_rdata2 <= w_mem[w_addr2[5:0]];
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // per-cycle trace of the main instance, indexed by cycle number
   logic [2:0]  tr_ctrl [0:511];
   logic        tr_ird [0:511];
   logic        tr_wrd [0:511];
   logic        tr_iv [0:511];
   logic        tr_wv [0:511];
   logic        tr_busy [0:511];
   logic        tr_done [0:511];
   logic [15:0] tr_res [0:511];
   logic [63:0] iq [$];
   logic [63:0] wq [$];
   logic [15:0] iaq [$];
   logic [15:0] waq [$];
   int          ctrl_edges [$];
   int          done_cyc [$];
   int          n_ovl;

   typedef struct {
      int         cyc;
      logic [2:0] ctrl;
      logic       i_rd, w_rd, i_valid, w_valid, busy, done;
   } vec_t;
   vec_t tbl [$];

   int exp_edges [0:7] = '{14, 46, 51, 83, 96, 128, 133, 165};

   task automatic start_run();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Start a run, then record n cycles while driving finish/res_valid/start/rst
   task automatic run(input int n, input int fin_cyc, input bit res_tog,
                      input int rs_a, input int rs_b, input int rst_cyc);
      logic [2:0] prev_ctrl;
      iq.delete(); wq.delete(); iaq.delete(); waq.delete();
      ctrl_edges.delete(); done_cyc.delete();
      n_ovl = 0;
      prev_ctrl = 3'd0;
      start_run();
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         tr_ctrl[k] = ctrl; tr_ird[k] = i_rd; tr_wrd[k] = w_rd;
         tr_iv[k] = i_valid; tr_wv[k] = w_valid;
         tr_busy[k] = busy; tr_done[k] = done; tr_res[k] = res_cnt;
         if (ctrl !== prev_ctrl) ctrl_edges.push_back(k);
         prev_ctrl = ctrl;
         if (i_valid) iq.push_back(i_data);
         if (w_valid) wq.push_back(w_data);
         if (i_rd) iaq.push_back(i_addr);
         if (w_rd) waq.push_back(w_addr);
         if (i_valid && w_valid) n_ovl++;
         if (done) done_cyc.push_back(k);
         finish    = (k == fin_cyc);
         res_valid = res_tog && (k % 2 == 1) && (k < 400);
         start     = (k == rs_a) || (k == rs_b);
         if (rst_cyc > 0 && k == rst_cyc) begin
            rst = 1'b0;
            #1;
            check("rst_async_outputs",
                  64'({busy, done, res_cnt, i_rd, i_addr, w_rd, w_addr, ctrl, i_valid, w_valid}),
                  64'd0);
            check("rst_async_data", i_data | w_data, 64'd0);
         end
         if (rst_cyc > 0 && k == rst_cyc + 2) rst = 1'b1;
      end
      finish = 1'b0; res_valid = 1'b0; start = 1'b0;
   endtask

   // Full default-run timeline: table, beat data, addresses, ctrl edges, done
   task automatic check_default(input string tag);
      for (int v = 0; v < tbl.size(); v++) begin
         int c;
         c = tbl[v].cyc;
         check($sformatf("%s_vec_c%0d", tag, c),
               64'({tr_ctrl[c], tr_ird[c], tr_wrd[c], tr_iv[c], tr_wv[c], tr_busy[c], tr_done[c]}),
               64'({tbl[v].ctrl, tbl[v].i_rd, tbl[v].w_rd, tbl[v].i_valid, tbl[v].w_valid,
                    tbl[v].busy, tbl[v].done}));
      end
      check($sformatf("%s_i_beats", tag), 64'(iq.size()), 64'd16);
      check($sformatf("%s_w_beats", tag), 64'(wq.size()), 64'd16);
      for (int b = 0; b < 16; b++) begin
         check($sformatf("%s_i_data%0d", tag, b),
               (b < iq.size()) ? iq[b] : 64'hDEAD_DEAD_DEAD_DEAD, i_mem[b]);
         check($sformatf("%s_w_data%0d", tag, b),
               (b < wq.size()) ? wq[b] : 64'hDEAD_DEAD_DEAD_DEAD, w_mem[b % 8]);
         check($sformatf("%s_i_addr%0d", tag, b),
               (b < iaq.size()) ? 64'(iaq[b]) : 64'hFFFF_FFFF, 64'(b));
         check($sformatf("%s_w_addr%0d", tag, b),
               (b < waq.size()) ? 64'(waq[b]) : 64'hFFFF_FFFF, 64'(b % 8));
      end
      check($sformatf("%s_ctrl_edge_cnt", tag), 64'(ctrl_edges.size()), 64'd8);
      for (int e = 0; e < 8; e++)
         check($sformatf("%s_ctrl_edge%0d", tag, e),
               (e < ctrl_edges.size()) ? 64'(ctrl_edges[e]) : 64'hFFFF_FFFF, 64'(exp_edges[e]));
      check($sformatf("%s_done_cnt", tag), 64'(done_cyc.size()), 64'd1);
      check($sformatf("%s_done_cyc", tag),
            (done_cyc.size() > 0) ? 64'(done_cyc[0]) : 64'hFFFF_FFFF, 64'd171);
      check($sformatf("%s_overlap", tag), 64'(n_ovl), 64'd0);
      check($sformatf("%s_res_cnt", tag), 64'(tr_res[172]), 64'd0);
   endtask

   initial begin
      for (int a = 0; a < 64; a++) begin
         i_mem[a] = 64'h1100_0000_0000_0000 + 64'(a) * 64'h0001_0001_0001;
         w_mem[a] = 64'h2200_0000_0000_0000 + 64'(a) * 64'h0003_0000_0007;
      end
      //                cyc ctrl ird wrd iv wv busy done
      tbl.push_back('{  1, 3'd0, 1, 0, 0, 0, 1, 0});
      tbl.push_back('{  2, 3'd0, 1, 0, 1, 0, 1, 0});
      tbl.push_back('{  8, 3'd0, 1, 0, 1, 0, 1, 0});
      tbl.push_back('{  9, 3'd0, 0, 1, 1, 0, 1, 0});
      tbl.push_back('{ 10, 3'd0, 0, 1, 0, 1, 1, 0});
      tbl.push_back('{ 12, 3'd0, 0, 1, 0, 1, 1, 0});
      tbl.push_back('{ 13, 3'd0, 0, 0, 0, 1, 1, 0});
      tbl.push_back('{ 14, 3'd1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{ 45, 3'd1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{ 46, 3'd2, 0, 1, 0, 0, 1, 0});
      tbl.push_back('{ 47, 3'd2, 0, 1, 0, 1, 1, 0});
      tbl.push_back('{ 50, 3'd2, 0, 0, 0, 1, 1, 0});
      tbl.push_back('{ 51, 3'd1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{ 82, 3'd1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{ 83, 3'd2, 1, 0, 0, 0, 1, 0});
      tbl.push_back('{ 91, 3'd2, 0, 1, 1, 0, 1, 0});
      tbl.push_back('{ 95, 3'd2, 0, 0, 0, 1, 1, 0});
      tbl.push_back('{ 96, 3'd1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{164, 3'd1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{165, 3'd0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{170, 3'd0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{171, 3'd0, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{172, 3'd0, 0, 0, 0, 0, 0, 0});

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            64'({busy, done, res_cnt, i_rd, i_addr, w_rd, w_addr, ctrl, i_valid, w_valid}), 64'd0);
      check("reset_data", i_data | w_data, 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset", 64'({busy, done, i_rd, w_rd, ctrl}), 64'd0);

      // default run, finish 5 cycles into FLUSH
      run(175, 170, 1'b0, -1, -1, -1);
      check_default("base");

      // finish seen before FLUSH
      run(175, 100, 1'b0, -1, -1, -1);
      check("early_done_cnt", 64'(done_cyc.size()), 64'd1);
      check("early_done_cyc", (done_cyc.size() > 0) ? 64'(done_cyc[0]) : 64'hFFFF_FFFF, 64'd166);
      check("early_flush", 64'({tr_ctrl[165], tr_busy[165]}), 64'({3'd0, 1'b1}));
      check("early_busy_drop", 64'({tr_busy[166], tr_done[166]}), 64'({1'b0, 1'b1}));
      check("early_i_beats", 64'(iq.size()), 64'd16);

      // 200 res_valid pulses, result held after done
      run(410, 400, 1'b1, -1, -1, -1);
      check("res_done_cyc", (done_cyc.size() > 0) ? 64'(done_cyc[0]) : 64'hFFFF_FFFF, 64'd401);
      check("res_cnt_at_done", 64'(tr_res[401]), 64'd200);
      check("res_cnt_held", 64'(tr_res[410]), 64'd200);

      // next start clears the count and replays the default timeline
      run(175, 170, 1'b0, -1, -1, -1);
      check("res_cnt_cleared", 64'(tr_res[1]), 64'd0);
      check_default("clr");

      // start re-pulsed while busy is ignored
      run(175, 170, 1'b0, 20, 60, -1);
      check_default("restart");

      // async reset mid-run
      run(60, -1, 1'b0, -1, -1, 30);
      check("rst_no_done", 64'(done_cyc.size()), 64'd0);
      check("rst_idle_c31", 64'({tr_ctrl[31], tr_ird[31], tr_wrd[31], tr_iv[31], tr_wv[31], tr_busy[31]}), 64'd0);
      check("rst_idle_c45", 64'({tr_ctrl[45], tr_ird[45], tr_wrd[45], tr_iv[45], tr_wv[45], tr_busy[45]}), 64'd0);
      run(175, 170, 1'b0, -1, -1, -1);
      check_default("rerun");

      // weight address wrap with a single stored weight set
      begin
         logic [15:0] waq2 [$];
         logic [63:0] wq2 [$];
         logic [63:0] ix2, ix_exp;
         int ni2, nd2, bad2;
         ix2 = '0; ix_exp = '0; ni2 = 0; nd2 = 0; bad2 = 0;
         for (int a = 0; a < 16; a++) ix_exp ^= i_mem[a];
         @(negedge clk);
         start2 = 1'b1;
         @(posedge clk);
         #1 start2 = 1'b0;
         for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (w_rd2) waq2.push_back(w_addr2);
            if (w_valid2) wq2.push_back(w_data2);
            if (i_valid2) begin ni2++; ix2 ^= i_data2; end
            if (done2) nd2++;
            if (ctrl2 > 3'd2 || (i_valid2 && w_valid2)) bad2++;
         end
         check("wrap_w_reads", 64'(waq2.size()), 64'd16);
         for (int b = 0; b < 16; b++) begin
            check($sformatf("wrap_w_addr%0d", b),
                  (b < waq2.size()) ? 64'(waq2[b]) : 64'hFFFF_FFFF, 64'(b % 4));
            check($sformatf("wrap_w_data%0d", b),
                  (b < wq2.size()) ? wq2[b] : 64'hDEAD_DEAD_DEAD_DEAD, w_mem[b % 4]);
         end
         check("wrap_i_beats", 64'(ni2), 64'd16);
         check("wrap_i_xor", ix2, ix_exp);
         check("wrap_done_cnt", 64'(nd2), 64'd1);
         check("wrap_protocol", 64'(bad2), 64'd0);
         check("wrap_idle", 64'({busy2, res_cnt2}), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
